mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-port arbiter between CPU/cache (port 0) and a DMA-style loader (port 1), sharing one memory controller port.
- Each requester sees a memory-like interface: request pulse, ready low while busy, ready high with result.
- Requests are latched per port, so simultaneous requests are never lost.
- The memory controller is driven by one sequencer that issues a single transaction at a time.

Parameters:
- ARB_MODE, 0, 0 = round-robin on ties; 1 = port 0 always wins ties.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- burst_en0  in  1  port 0 burst request
- burst_length0  in  8  port 0 burst length
- a0  in  AW  port 0 address
- d0  in  DW  port 0 write data
- we0  in  1  port 0 write request pulse
- rd0  in  1  port 0 read request pulse
- spo0  out  DW  port 0 read data
- ready0  out  1  port 0 idle/done
- burst_en1, burst_length1, a1, d1, we1, rd1, spo1, ready1: same as port 0, for port 1
- burst_en_mem  out  1  to memory
- burst_length_mem  out  8  to memory
- a_mem  out  AW  to memory
- d_mem  out  DW  to memory
- we_mem  out  1  one-cycle write pulse
- rd_mem  out  1  one-cycle read pulse
- spo_mem  in  DW  memory read data
- ready_mem  in  1  memory done/idle
- grant  out  2  one-hot current owner (debug); 0 when idle

Behaviour:
- Reset: rst, synchronous, active-high; clock clk, all flops on posedge.
  - Reset values: ready0 = ready1 = 1; spo0 = spo1 = 0; we_mem = rd_mem = burst_en_mem = 0; a_mem = d_mem = burst_length_mem = 0; grant = 0.
  - Pending flags cleared; state IDLE; last_grant = 1, so port 0 wins the first tie.
- Accept:
  - When readyX == 1 and (weX | rdX), latch a/d/burst_en/burst_length/op into slot X and set pendingX.
  - readyX goes 0 the next cycle.
  - weX & rdX together is treated as a write.
  - weX/rdX while readyX == 0 are ignored; no queueing beyond one per port.
- FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI.
  - IDLE: if any pendingX, select the owner and go to ISSUE.
    - Only one pending: that port is selected.
    - Both pending, ARB_MODE 0: select the port != last_grant.
    - Both pending, ARB_MODE 1: select port 0.
  - ISSUE (1 cycle): drive we_mem or rd_mem high with the owner's latched signals.
  - WAIT_LO (1 cycle): ready_mem is ignored. Memory contract: ready_mem drops within one cycle of a request pulse.
  - WAIT_HI: stay until ready_mem == 1. On that cycle:
    - For reads, capture spo_mem into spoX; writes leave spoX unchanged.
    - Clear pendingX; readyX = 1 next cycle; last_grant = X; go to IDLE.
- Memory-side outputs:
  - a_mem, d_mem, burst_en_mem, burst_length_mem hold owner values from ISSUE through the end of WAIT_HI; they hold their last value in IDLE.
  - grant is one-hot in ISSUE, WAIT_LO and WAIT_HI.
- Burst: burst_en and length are forwarded unchanged. During WAIT_HI of a burst read, spoX = spo_mem combinationally so the requester sees each beat. The transaction ends on ready_mem == 1 as above.
- Latency:
  - Request pulse at cycle T → pending at T+1 → ISSUE (we_mem/rd_mem high) at T+2 → WAIT_LO at T+3 → WAIT_HI from T+4.
  - If ready_mem == 1 at T+4, readyX = 1 at T+5.
  - Minimum 5 cycles; a request arriving while the other port is owned waits for IDLE.
- Reset mid-operation: the in-flight memory transaction is abandoned; all outputs take reset values next cycle; pending requests are dropped.
- Fairness: in ARB_MODE 0, with both ports re-requesting immediately after their ready, grants strictly alternate.

Decomposition:
- Package mem_arb_pkg:
  - FSM state encoding (2 bits);
  - port ID constants PORT_CPU = 0, PORT_LDR = 1;
  - op encoding OP_RD/OP_WR.
- Sub-module mem_req_slot (instantiated twice): capture registers, pending flag, ready/spo output logic, completion input.
- Top level holds the FSM, tie-break and memory mux.

Test Plan:
1. Port 0 rd0 pulse, a0 = 0x100; memory model returns 0x12345678 with ready_mem high 3 cycles after the pulse → rd_mem high exactly 1 cycle at T+2 with a_mem = 0x100; ready0 low T+1..T+5; spo0 = 0x12345678 when ready0 rises.
2. After reset, we0 (a0 = 0x10, d0 = 0xA) and we1 (a1 = 0x20, d1 = 0xB) in the same cycle → port 0 write issued first, then port 1; ready1 stays low until its own completion; d_mem = 0xA then 0xB.
3. ARB_MODE 0, both ports re-request on every ready rise for 8 transactions → grant sequence 01,10,01,10…; ARB_MODE 1 gives the same sequence, because each port can hold only one pending request.
4. rd0 pulsed again while ready0 = 0 → exactly one rd_mem pulse in total; no extra transaction.
5. we1 and rd1 asserted together, a1 = 0x40 → we_mem pulse only; spo1 unchanged.
6. rst asserted during WAIT_HI with both ports pending → next cycle ready0 = ready1 = 1, grant = 0, and no further we_mem/rd_mem pulses without new requests.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: sequencer states,
// port identifiers, operation codes and the tie-break helper.
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_WAIT_LO = 2'd2;
    localparam state_t ST_WAIT_HI = 2'd3;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // On a tie, fixed priority favours the CPU; otherwise the port not served last wins.
    function automatic logic pick_owner(input logic pend0, input logic pend1,
                                        input logic last_grant, input logic port0_priority);
        logic sel;
        if (pend0 && pend1) begin
            if (port0_priority) begin
                sel = PORT_CPU;
            end else begin
                sel = ~last_grant;
            end
        end else if (pend1) begin
            sel = PORT_LDR;
        end else begin
            sel = PORT_CPU;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One requester slot: captures a single request, holds it pending until the
// sequencer reports completion, and presents ready/read data to the requester.
module mem_req_slot import mem_arb_pkg::*; #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          burst_en,
    input  logic [7:0]    burst_length,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    input  logic          we,
    input  logic          rd,
    input  logic          done,
    input  logic          stream,
    input  logic [DW-1:0] spo_mem,
    output logic          pending,
    output logic          op,
    output logic [AW-1:0] lat_a,
    output logic [DW-1:0] lat_d,
    output logic          lat_burst_en,
    output logic [7:0]    lat_burst_length,
    output logic          ready,
    output logic [DW-1:0] spo
);

    logic          ready_r;
    logic [DW-1:0] spo_r;
    logic          accept_s;

    assign accept_s = ready_r & (we | rd);

    // Capture on accept, release on completion; a write wins when both strobes are high.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r          <= 1'b1;
            pending          <= 1'b0;
            op               <= OP_RD;
            lat_a            <= '0;
            lat_d            <= '0;
            lat_burst_en     <= 1'b0;
            lat_burst_length <= 8'd0;
            spo_r            <= '0;
        end else if (accept_s) begin
            ready_r          <= 1'b0;
            pending          <= 1'b1;
            op               <= we ? OP_WR : OP_RD;
            lat_a            <= a;
            lat_d            <= d;
            lat_burst_en     <= burst_en;
            lat_burst_length <= burst_length;
        end else if (done) begin
            ready_r <= 1'b1;
            pending <= 1'b0;
            if (op == OP_RD) begin
                spo_r <= spo_mem;
            end
        end
    end

    assign ready = ready_r;
    // Burst reads expose each beat as it arrives.
    assign spo   = stream ? spo_mem : spo_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one memory controller port: per-port request slots
// feed a single sequencer that runs one transaction at a time.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int ARB_MODE = 0,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          burst_en0,
    input  logic [7:0]    burst_length0,
    input  logic [AW-1:0] a0,
    input  logic [DW-1:0] d0,
    input  logic          we0,
    input  logic          rd0,
    output logic [DW-1:0] spo0,
    output logic          ready0,
    input  logic          burst_en1,
    input  logic [7:0]    burst_length1,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] d1,
    input  logic          we1,
    input  logic          rd1,
    output logic [DW-1:0] spo1,
    output logic          ready1,
    output logic          burst_en_mem,
    output logic [7:0]    burst_length_mem,
    output logic [AW-1:0] a_mem,
    output logic [DW-1:0] d_mem,
    output logic          we_mem,
    output logic          rd_mem,
    input  logic [DW-1:0] spo_mem,
    input  logic          ready_mem,
    output logic [1:0]    grant
);

    state_t        state_r;
    logic          owner_r;
    logic          last_grant_r;

    logic          pend0, pend1, op0, op1, lbe0, lbe1;
    logic [AW-1:0] la0, la1;
    logic [DW-1:0] ld0, ld1;
    logic [7:0]    lbl0, lbl1;
    logic          done0_s, done1_s, stream0_s, stream1_s, finish_s;

    logic          next_owner_s, sel_op_s, sel_be_s;
    logic [AW-1:0] sel_a_s;
    logic [DW-1:0] sel_d_s;
    logic [7:0]    sel_bl_s;

    assign finish_s  = (state_r == ST_WAIT_HI) && ready_mem;
    assign done0_s   = finish_s && (owner_r == PORT_CPU);
    assign done1_s   = finish_s && (owner_r == PORT_LDR);
    assign stream0_s = (state_r == ST_WAIT_HI) && (owner_r == PORT_CPU) && lbe0 && (op0 == OP_RD);
    assign stream1_s = (state_r == ST_WAIT_HI) && (owner_r == PORT_LDR) && lbe1 && (op1 == OP_RD);

    mem_req_slot #(.AW(AW), .DW(DW)) u_slot0 (
        .clk(clk), .rst(rst), .burst_en(burst_en0), .burst_length(burst_length0),
        .a(a0), .d(d0), .we(we0), .rd(rd0), .done(done0_s), .stream(stream0_s),
        .spo_mem(spo_mem), .pending(pend0), .op(op0), .lat_a(la0), .lat_d(ld0),
        .lat_burst_en(lbe0), .lat_burst_length(lbl0), .ready(ready0), .spo(spo0)
    );

    mem_req_slot #(.AW(AW), .DW(DW)) u_slot1 (
        .clk(clk), .rst(rst), .burst_en(burst_en1), .burst_length(burst_length1),
        .a(a1), .d(d1), .we(we1), .rd(rd1), .done(done1_s), .stream(stream1_s),
        .spo_mem(spo_mem), .pending(pend1), .op(op1), .lat_a(la1), .lat_d(ld1),
        .lat_burst_en(lbe1), .lat_burst_length(lbl1), .ready(ready1), .spo(spo1)
    );

    assign next_owner_s = pick_owner(pend0, pend1, last_grant_r, (ARB_MODE != 0));

    // Select the winning slot's latched request for the memory side.
    always_comb begin
        if (next_owner_s == PORT_LDR) begin
            sel_op_s = op1;
            sel_a_s  = la1;
            sel_d_s  = ld1;
            sel_be_s = lbe1;
            sel_bl_s = lbl1;
        end else begin
            sel_op_s = op0;
            sel_a_s  = la0;
            sel_d_s  = ld0;
            sel_be_s = lbe0;
            sel_bl_s = lbl0;
        end
    end

    // Sequencer: one transaction at a time, memory-side outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            owner_r          <= PORT_CPU;
            last_grant_r     <= PORT_LDR;
            we_mem           <= 1'b0;
            rd_mem           <= 1'b0;
            a_mem            <= '0;
            d_mem            <= '0;
            burst_en_mem     <= 1'b0;
            burst_length_mem <= 8'd0;
            grant            <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pend0 || pend1) begin
                        state_r          <= ST_ISSUE;
                        owner_r          <= next_owner_s;
                        we_mem           <= (sel_op_s == OP_WR);
                        rd_mem           <= (sel_op_s == OP_RD);
                        a_mem            <= sel_a_s;
                        d_mem            <= sel_d_s;
                        burst_en_mem     <= sel_be_s;
                        burst_length_mem <= sel_bl_s;
                        grant            <= (next_owner_s == PORT_LDR) ? 2'b10 : 2'b01;
                    end
                end
                ST_ISSUE: begin
                    we_mem  <= 1'b0;
                    rd_mem  <= 1'b0;
                    state_r <= ST_WAIT_LO;
                end
                // Memory may still show ready from before the pulse; skip one cycle.
                ST_WAIT_LO: begin
                    state_r <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (ready_mem) begin
                        state_r      <= ST_IDLE;
                        grant        <= 2'b00;
                        last_grant_r <= owner_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory responder model, a
// transaction scoreboard on the memory side, and per-port result checks.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        burst_en0 = 1'b0, burst_en1 = 1'b0;
    logic [7:0]  burst_length0 = 8'd0, burst_length1 = 8'd0;
    logic [31:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;
    logic        we0 = 1'b0, rd0 = 1'b0, we1 = 1'b0, rd1 = 1'b0;
    logic [31:0] spo0, spo1;
    logic        ready0, ready1;
    logic        burst_en_mem, we_mem, rd_mem;
    logic [7:0]  burst_length_mem;
    logic [31:0] a_mem, d_mem;
    logic [31:0] spo_mem;
    logic        ready_mem;
    logic [1:0]  grant;

    mem_port_arbiter #(.ARB_MODE(0), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .burst_en0(burst_en0), .burst_length0(burst_length0), .a0(a0), .d0(d0),
        .we0(we0), .rd0(rd0), .spo0(spo0), .ready0(ready0),
        .burst_en1(burst_en1), .burst_length1(burst_length1), .a1(a1), .d1(d1),
        .we1(we1), .rd1(rd1), .spo1(spo1), .ready1(ready1),
        .burst_en_mem(burst_en_mem), .burst_length_mem(burst_length_mem),
        .a_mem(a_mem), .d_mem(d_mem), .we_mem(we_mem), .rd_mem(rd_mem),
        .spo_mem(spo_mem), .ready_mem(ready_mem), .grant(grant)
    );

    always #5 clk = ~clk;

    // Memory model: ready drops after a pulse, returns MEM_LAT cycles after it.
    logic [31:0] mem_arr [0:255];
    int          mem_cnt;
    logic        rd_act;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 32'hA500_0000 | 32'(i);
            mem_arr[8'h40] <= 32'h1234_5678;
            ready_mem <= 1'b1;
            mem_cnt   <= 0;
            spo_mem   <= '0;
            rd_act    <= 1'b0;
        end else if (we_mem || rd_mem) begin
            ready_mem <= 1'b0;
            mem_cnt   <= MEM_LAT - 1;
            rd_act    <= rd_mem;
            if (we_mem) mem_arr[a_mem[9:2]] <= d_mem;
            else        spo_mem <= mem_arr[a_mem[9:2]];
        end else if (mem_cnt != 0) begin
            if (rd_act && burst_en_mem) spo_mem <= spo_mem + 32'd1;
            if (mem_cnt == 1) ready_mem <= 1'b1;
            mem_cnt <= mem_cnt - 1;
        end
    end

    typedef struct packed {
        logic [1:0]  g;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        b;
    } txn_t;

    typedef struct {
        int          p;
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_spo;
    } vec_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    logic prev_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Advance to the next falling edge and score any memory pulse seen there.
    task automatic tick();
        txn_t e;
        @(negedge clk);
        if (we_mem || rd_mem) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL mem_txn: unexpected pulse grant=%b we=%b rd=%b a=%h", grant, we_mem, rd_mem, a_mem);
            end else begin
                e = exp_q.pop_front();
                if (prev_pulse || grant !== e.g || we_mem !== e.w || rd_mem !== !e.w ||
                    a_mem !== e.a || burst_en_mem !== e.b || (e.w && d_mem !== e.d)) begin
                    n_err++;
                    $display("FAIL mem_txn: got grant=%b we=%b rd=%b a=%h d=%h b=%b prev=%b, expected grant=%b we=%b a=%h d=%h b=%b",
                             grant, we_mem, rd_mem, a_mem, d_mem, burst_en_mem, prev_pulse, e.g, e.w, e.a, e.d, e.b);
                end
            end
        end
        prev_pulse = we_mem || rd_mem;
    endtask

    task automatic drive(input int p, input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic b);
        if (p == 0) begin
            we0 = w; rd0 = r; a0 = a; d0 = d; burst_en0 = b; burst_length0 = b ? 8'd4 : 8'd0;
        end else begin
            we1 = w; rd1 = r; a1 = a; d1 = d; burst_en1 = b; burst_length1 = b ? 8'd4 : 8'd0;
        end
    endtask

    task automatic release_req();
        we0 = 1'b0; rd0 = 1'b0; we1 = 1'b0; rd1 = 1'b0;
    endtask

    task automatic expect_txn(input int p, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic b);
        txn_t e;
        e.g = (p == 0) ? 2'b01 : 2'b10;
        e.w = w; e.a = a; e.d = d; e.b = b;
        exp_q.push_back(e);
    endtask

    // Entered at the falling edge one cycle after the request; returns the cycle
    // offset from the request at which each ready was first seen high (-1 on timeout).
    task automatic wait_ready2(output int at0, output int at1);
        at0 = -1; at1 = -1;
        for (int n = 1; n <= 60 && (at0 < 0 || at1 < 0); n++) begin
            if (at0 < 0 && ready0) at0 = n;
            if (at1 < 0 && ready1) at1 = n;
            if (at0 < 0 || at1 < 0) tick();
        end
    endtask

    vec_t vecs [9];
    int   at0, at1, iss0, iss1, n;

    initial begin
        vecs[0] = '{0, 1'b0, 1'b1, 32'h100, 32'h0,    32'h1234_5678};
        vecs[1] = '{1, 1'b0, 1'b1, 32'h200, 32'h0,    32'hA500_0080};
        vecs[2] = '{1, 1'b1, 1'b1, 32'h40,  32'hDEAD, 32'hA500_0080};
        vecs[3] = '{1, 1'b0, 1'b1, 32'h40,  32'h0,    32'h0000_DEAD};
        vecs[4] = '{0, 1'b1, 1'b0, 32'h100, 32'hCAFE, 32'h1234_5678};
        vecs[5] = '{0, 1'b0, 1'b1, 32'h100, 32'h0,    32'h0000_CAFE};
        vecs[6] = '{0, 1'b0, 1'b1, 32'h10,  32'h0,    32'h0000_000A};
        vecs[7] = '{1, 1'b0, 1'b1, 32'h20,  32'h0,    32'h0000_000B};
        vecs[8] = '{0, 1'b1, 1'b0, 32'h50,  32'h55,   32'h0000_000A};

        // Reset values
        tick(); tick(); tick();
        check("rst_ready0", {31'd0, ready0}, 32'd1);
        check("rst_ready1", {31'd0, ready1}, 32'd1);
        check("rst_spo0", spo0, 32'd0);
        check("rst_spo1", spo1, 32'd0);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_pulses", {30'd0, we_mem, rd_mem}, 32'd0);
        check("rst_a_mem", a_mem, 32'd0);
        check("rst_burst", {23'd0, burst_en_mem, burst_length_mem}, 32'd0);
        rst = 1'b0;
        tick();

        // Simultaneous writes straight after reset: port 0 wins the first tie
        drive(0, 1'b1, 1'b0, 32'h10, 32'hA, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'hB, 1'b0);
        expect_txn(0, 1'b1, 32'h10, 32'hA, 1'b0);
        expect_txn(1, 1'b1, 32'h20, 32'hB, 1'b0);
        tick(); release_req();
        wait_ready2(at0, at1);
        check("tie0_ready0_at", 32'(at0), 32'd6);
        check("tie0_ready1_at", 32'(at1), 32'd11);

        // Single transactions from the vector table
        foreach (vecs[i]) begin
            drive(vecs[i].p, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, 1'b0);
            expect_txn(vecs[i].p, vecs[i].w, vecs[i].a, vecs[i].d, 1'b0);
            tick(); release_req();
            wait_ready2(at0, at1);
            if (vecs[i].p == 0) begin
                check($sformatf("vec%0d_ready_at", i), 32'(at0), 32'd6);
                check($sformatf("vec%0d_spo0", i), spo0, vecs[i].exp_spo);
            end else begin
                check($sformatf("vec%0d_ready_at", i), 32'(at1), 32'd6);
                check($sformatf("vec%0d_spo1", i), spo1, vecs[i].exp_spo);
            end
        end

        // Tie after port 0 was served last: round-robin picks port 1
        drive(0, 1'b1, 1'b0, 32'h30, 32'h1, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h34, 32'h2, 1'b0);
        expect_txn(1, 1'b1, 32'h34, 32'h2, 1'b0);
        expect_txn(0, 1'b1, 32'h30, 32'h1, 1'b0);
        tick(); release_req();
        wait_ready2(at0, at1);
        check("rr_ready1_at", 32'(at1), 32'd6);
        check("rr_ready0_at", 32'(at0), 32'd11);

        // Second rd0 while busy is ignored
        drive(0, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0);
        expect_txn(0, 1'b0, 32'h100, 32'h0, 1'b0);
        tick(); release_req();
        check("busy_ready0", {31'd0, ready0}, 32'd0);
        drive(0, 1'b0, 1'b1, 32'h104, 32'h0, 1'b0);
        tick(); release_req();
        wait_ready2(at0, at1);
        check("busy_ready0_at", 32'(at0), 32'd5);
        check("busy_spo0", spo0, 32'h0000_CAFE);
        for (int k = 0; k < 10; k++) tick();

        // Burst read on port 1: beats visible on spo1 during WAIT_HI
        drive(1, 1'b0, 1'b1, 32'h80, 32'h0, 1'b1);
        expect_txn(1, 1'b0, 32'h80, 32'h0, 1'b1);
        tick(); release_req();
        tick(); tick(); tick();
        check("burst_len_mem", {24'd0, burst_length_mem}, 32'd4);
        check("burst_beat1", spo1, 32'hA500_0021);
        tick();
        check("burst_beat2", spo1, 32'hA500_0022);
        tick();
        check("burst_ready1", {31'd0, ready1}, 32'd1);
        check("burst_spo1", spo1, 32'hA500_0022);

        // Fairness: both ports re-request as soon as they are ready
        burst_en0 = 1'b0; burst_en1 = 1'b0; a0 = 32'h60; a1 = 32'h64;
        for (int k = 0; k < 8; k++) expect_txn(k % 2, 1'b0, (k % 2 == 0) ? 32'h60 : 32'h64, 32'h0, 1'b0);
        iss0 = 0; iss1 = 0; n = 0;
        while ((iss0 < 4 || iss1 < 4 || !ready0 || !ready1) && n < 300) begin
            rd0 = ready0 && (iss0 < 4);
            rd1 = ready1 && (iss1 < 4);
            if (rd0) iss0++;
            if (rd1) iss1++;
            tick();
            n++;
        end
        release_req();
        check("fair_bound", {31'd0, n < 300}, 32'd1);
        check("fair_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during WAIT_HI with both ports pending
        drive(0, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0);
        drive(1, 1'b0, 1'b1, 32'h200, 32'h0, 1'b0);
        expect_txn(0, 1'b0, 32'h100, 32'h0, 1'b0);
        tick(); release_req();
        tick(); tick(); tick();
        check("midrst_grant_before", {30'd0, grant}, 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_ready0", {31'd0, ready0}, 32'd1);
        check("midrst_ready1", {31'd0, ready1}, 32'd1);
        check("midrst_grant", {30'd0, grant}, 32'd0);
        check("midrst_spo0", spo0, 32'd0);
        check("midrst_pulses", {30'd0, we_mem, rd_mem}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
